pipe_accum: RTL and testbench
=============================

# pipe_accum

Downstream consumer for the arithmetic pipeline's registered result (`Q_pipe`). It accepts one WIDTH-bit result per valid beat and accumulates NSAMP accepted beats into an ACC_W-bit block sum while tracking the block maximum. It then presents the sum and maximum to the next stage over a valid/ready handshake, holding the result until that stage takes it.

## Interface
- `WIDTH`, default 4: width of incoming pipeline results (unsigned).
- `NSAMP`, default 4: accepted samples per block; legal range 1..255.
- `ACC_W`, default 8: width of the block sum; must be ≥ WIDTH.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `n_rst`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: `in_data` carries a result this cycle.
- `in_ready`, output, 1: block can accept `in_data` this cycle.
- `in_data`, input, WIDTH: pipeline result (connect to `Q_pipe`).
- `out_valid`, output, 1: `out_sum`, `out_max` and `out_ovf` are valid.
- `out_ready`, input, 1: downstream accepts the result this cycle.
- `out_sum`, output, ACC_W: sum of the NSAMP samples in the block.
- `out_max`, output, WIDTH: largest sample in the block.
- `out_ovf`, output, 1: the block sum exceeded 2^ACC_W−1.
- `busy`, output, 1: a block is partially accumulated or being held.

## Operation
- The FSM has three states: IDLE, ACCUM and HOLD. The reset state is IDLE.
- An input beat is accepted on a rising edge when `in_valid && in_ready`.
- `in_ready` is 1 in IDLE and ACCUM and 0 in HOLD. It is decoded combinationally from state.
- IDLE → ACCUM on the first accepted beat. On that edge:
  - acc = in_data.
  - max = in_data.
  - cnt = 1.
  - ovf = 0.
- ACCUM, on each further accepted beat:
  - acc += in_data, zero-extended to ACC_W+1 bits before the add.
  - max = larger of max and in_data.
  - cnt += 1.
  - ovf |= carry out of bit ACC_W−1.
- Non-accepted cycles (`in_valid=0`) leave all state unchanged. There is no timeout.
- Completing a block: the beat that makes cnt equal NSAMP loads the output registers and moves the FSM to HOLD.
- NSAMP=1: the first beat goes straight from IDLE to HOLD.
- HOLD:
  - `out_valid=1`.
  - `out_sum`, `out_max` and `out_ovf` are stable.
  - `in_data` and `in_valid` are ignored.
- HOLD → IDLE on the edge where `out_ready=1`. On that edge `out_valid` drops, cnt and acc clear, and `out_*` keep their last values.
- `busy` = (state ≠ IDLE).
- Reset mid-block discards the partial block and any held result. It takes effect asynchronously and leaves no residue in the next block.
- Reset values:
  - `out_valid` 0.
  - `out_sum` 0.
  - `out_max` 0.
  - `out_ovf` 0.
  - `busy` 0.
  - `in_ready` 1.
  - Internal acc, max and cnt 0.

## Timing
- `out_valid` rises on the clock edge that accepts the NSAMP-th beat. It is visible in the following cycle.
- Minimum block period is NSAMP+1 cycles: NSAMP accept cycles plus at least one HOLD cycle.
- `out_valid` and the `out_*` registers are flop outputs. `in_ready` is combinational from state only, with no combinational path from `out_ready`.
- A beat offered while in HOLD is not accepted. Upstream must hold it, or accept that it is dropped if the upstream stage does not honour `in_ready`.

## Configuration
- Macro `PIPE_ACCUM_SAT_EN`.
- Defined: the accumulator saturates. When an add carries out, acc clamps to 2^ACC_W−1 and stays there for the rest of the block. `out_ovf` is set.
- Undefined: the accumulator wraps modulo 2^ACC_W. `out_ovf` is still set on any carry.

## Test plan
- Reset: hold `n_rst=0` with `in_valid=1` and `in_data=9` → `out_valid=0`, `out_sum=0`, `out_max=0`, `out_ovf=0`, `busy=0`, `in_ready=1`.
- Back-to-back block (defaults): beats 3, 5, 7, 1 on consecutive cycles with `out_ready=1` → `out_valid=1` for exactly one cycle, `out_sum=16`, `out_max=7`, `out_ovf=0`; then IDLE.
- Backpressure: complete a block of 2, 2, 2, 2 with `out_ready=0` for 5 cycles while `in_valid=1`, `in_data=15` → `out_valid` held, `out_sum=8` stable, `in_ready=0`, the 15s are not counted. Raise `out_ready` → HOLD to IDLE after one edge.
- Gapped input: beats 4, –, 6, –, –, 2, 1, where – means `in_valid=0` → `out_sum=13`, `out_max=6`. `out_valid` rises after the 4th valid beat only.
- Overflow, ACC_W=5 build: beats 15, 15, 15, 15 → wrap build gives `out_sum=28`, `out_ovf=1`; `PIPE_ACCUM_SAT_EN` build gives `out_sum=31`, `out_ovf=1`.
- Reset mid-block: accept 9, 9, then pulse `n_rst` low, then beats 1, 1, 1, 1 → `out_sum=4`, `out_max=1`, `out_ovf=0`.

Source files
------------

// File: rtl/pipe_accum.sv
// pipe_accum: block accumulator that sits downstream of the arithmetic
// pipeline's registered result (Q_pipe).
//
// It accepts NSAMP unsigned WIDTH-bit samples over a valid/ready input.
// It forms their ACC_W-bit sum and tracks the block maximum. The result
// is held on a valid/ready output until the next stage takes it.
//
// Build option: define PIPE_ACCUM_SAT_EN to make the accumulator saturate
// at 2^ACC_W-1 instead of wrapping. The carry flag (out_ovf) is reported
// in both builds.
//
// Ports
//   clk        in   rising-edge clock
//   n_rst      in   asynchronous active-low reset
//   in_valid   in   in_data carries a sample this cycle
//   in_ready   out  block can take a sample (low while a result is held)
//   in_data    in   WIDTH-bit unsigned sample
//   out_valid  out  out_sum / out_max / out_ovf are valid
//   out_ready  in   downstream takes the result this cycle
//   out_sum    out  ACC_W-bit block sum
//   out_max    out  largest sample of the block
//   out_ovf    out  block sum carried past 2^ACC_W-1
//   busy       out  a block is partially accumulated or being held
module pipe_accum #(
  parameter int WIDTH = 4,
  parameter int NSAMP = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [WIDTH-1:0] out_max,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [WIDTH-1:0] r_max;
  logic [7:0]       r_cnt;
  logic             r_ovf;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_sum;
  logic [WIDTH-1:0] r_out_max;
  logic             r_out_ovf;

  logic             w_accept;
  logic             w_first;
  logic [ACC_W-1:0] w_base;
  logic [ACC_W:0]   w_sum_ext;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_max_nxt;
  logic [7:0]       w_cnt_nxt;
  logic             w_ovf_nxt;
  logic             w_done;

  // Clamp or wrap the widened sum back to ACC_W bits.
  function automatic logic [ACC_W-1:0] f_acc_limit(input logic [ACC_W:0] sum);
`ifdef PIPE_ACCUM_SAT_EN
    return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    return sum[ACC_W-1:0];
`endif
  endfunction

  assign in_ready  = (r_state != HOLD);
  assign w_accept  = in_valid && in_ready;
  assign w_first   = (r_state == IDLE);

  // The first beat of a block adds onto zero. That merges the load and
  // accumulate paths, and it can never carry because ACC_W >= WIDTH.
  assign w_base    = w_first ? '0 : r_acc;
  assign w_sum_ext = {1'b0, w_base} + {{(ACC_W + 1 - WIDTH){1'b0}}, in_data};
  assign w_acc_nxt = f_acc_limit(w_sum_ext);
  assign w_max_nxt = (w_first || (in_data > r_max)) ? in_data : r_max;
  assign w_cnt_nxt = w_first ? 8'd1 : 8'(r_cnt + 8'd1);
  assign w_ovf_nxt = (w_first ? 1'b0 : r_ovf) | w_sum_ext[ACC_W];
  assign w_done    = (w_cnt_nxt == 8'(NSAMP));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_max       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_max   <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          if (w_accept) begin
            r_acc <= w_acc_nxt;
            r_max <= w_max_nxt;
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_nxt;
            if (w_done) begin
              // The final beat goes straight into the output registers.
              r_out_sum   <= w_acc_nxt;
              r_out_max   <= w_max_nxt;
              r_out_ovf   <= w_ovf_nxt;
              r_out_valid <= 1'b1;
              r_state     <= HOLD;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        HOLD: begin
          // Outputs keep their last values after the handshake.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_max       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_max   = r_out_max;
  assign out_ovf   = r_out_ovf;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_pipe_accum.sv
module tb_pipe_accum;

  typedef struct {
    int sum;
    int max;
    int ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       out_ready = 1'b1;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_sum;
  logic [3:0] out_max;
  logic       out_ovf;
  logic       busy;

  logic       ov_valid = 1'b0;
  logic [3:0] ov_data = '0;
  logic       ov_ready = 1'b1;
  logic       ov_in_ready;
  logic       ov_out_valid;
  logic [4:0] ov_out_sum;
  logic [3:0] ov_out_max;
  logic       ov_out_ovf;
  logic       ov_busy;

  int n_checks = 0;
  int n_pass = 0;
  exp_t q_main[$];
  exp_t q_ov[$];

  always #5 clk = ~clk;

  pipe_accum #(.WIDTH(4), .NSAMP(4), .ACC_W(8)) u_dut (
    .clk(clk), .n_rst(n_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_max(out_max), .out_ovf(out_ovf), .busy(busy)
  );

  pipe_accum #(.WIDTH(4), .NSAMP(4), .ACC_W(5)) u_ovf (
    .clk(clk), .n_rst(n_rst),
    .in_valid(ov_valid), .in_ready(ov_in_ready), .in_data(ov_data),
    .out_valid(ov_out_valid), .out_ready(ov_ready),
    .out_sum(ov_out_sum), .out_max(ov_out_max), .out_ovf(ov_out_ovf),
    .busy(ov_busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push_main(input int s, input int m, input int o);
    exp_t e;
    e.sum = s; e.max = m; e.ovf = o;
    q_main.push_back(e);
  endtask

  task automatic beat(input logic v, input logic [3:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop one expected result per output handshake.
  always @(negedge clk) begin
    if (n_rst && out_valid && out_ready) begin
      if (q_main.size() == 0) begin
        chk("main_unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = q_main.pop_front();
        chk("main_sum", int'(out_sum), e.sum);
        chk("main_max", int'(out_max), e.max);
        chk("main_ovf", int'(out_ovf), e.ovf);
      end
    end
  end

  always @(negedge clk) begin
    if (n_rst && ov_out_valid && ov_ready) begin
      if (q_ov.size() == 0) begin
        chk("ovf_unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = q_ov.pop_front();
        chk("ovf_sum", int'(ov_out_sum), e.sum);
        chk("ovf_max", int'(ov_out_max), e.max);
        chk("ovf_ovf", int'(ov_out_ovf), e.ovf);
      end
    end
  end

  initial begin
    // Reset held with a live input beat.
    n_rst = 1'b0;
    in_valid = 1'b1;
    in_data = 4'd9;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_out_max", int'(out_max), 0);
    chk("rst_out_ovf", int'(out_ovf), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    in_valid = 1'b0;
    #2 n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back block with the consumer always ready.
    out_ready = 1'b1;
    push_main(16, 7, 0);
    beat(1, 4'd3);
    beat(1, 4'd5);
    beat(1, 4'd7);
    beat(1, 4'd1);
    in_valid = 1'b0;
    chk("b2b_valid_rise", int'(out_valid), 1);
    @(posedge clk);
    #1;
    chk("b2b_valid_one_cycle", int'(out_valid), 0);
    chk("b2b_idle", int'(busy), 0);

    // Backpressure: result held while new beats are offered.
    out_ready = 1'b0;
    push_main(8, 2, 0);
    beat(1, 4'd2);
    beat(1, 4'd2);
    beat(1, 4'd2);
    beat(1, 4'd2);
    in_valid = 1'b1;
    in_data = 4'd15;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_out_sum", int'(out_sum), 8);
      chk("bp_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", int'(out_valid), 0);
    chk("bp_release_idle", int'(busy), 0);

    // Gapped input stream.
    push_main(13, 6, 0);
    beat(1, 4'd4);
    beat(0, 4'd0);
    beat(1, 4'd6);
    beat(0, 4'd0);
    beat(0, 4'd0);
    beat(1, 4'd2);
    chk("gap_no_early_valid", int'(out_valid), 0);
    beat(1, 4'd1);
    in_valid = 1'b0;
    chk("gap_valid_after_4th", int'(out_valid), 1);
    @(posedge clk);
    #1;

    // Reset in the middle of a block leaves no residue.
    beat(1, 4'd9);
    beat(1, 4'd9);
    in_valid = 1'b0;
    chk("mid_busy_before_rst", int'(busy), 1);
    #2 n_rst = 1'b0;
    #1;
    chk("mid_busy_in_rst", int'(busy), 0);
    #2 n_rst = 1'b1;
    @(posedge clk);
    #1;
    push_main(4, 1, 0);
    beat(1, 4'd1);
    beat(1, 4'd1);
    beat(1, 4'd1);
    beat(1, 4'd1);
    in_valid = 1'b0;
    chk("mid_valid", int'(out_valid), 1);
    @(posedge clk);
    #1;

    // Overflow on the 5-bit accumulator instance.
    begin
      exp_t e;
`ifdef PIPE_ACCUM_SAT_EN
      e.sum = 31;
`else
      e.sum = 28;
`endif
      e.max = 15;
      e.ovf = 1;
      q_ov.push_back(e);
    end
    ov_valid = 1'b1;
    ov_data = 4'd15;
    repeat (4) @(posedge clk);
    #1;
    ov_valid = 1'b0;
    chk("ovf_valid", int'(ov_out_valid), 1);

    // Drain: every expected result must have been observed.
    for (int i = 0; i < 20; i++) begin
      if (q_main.size() == 0 && q_ov.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("main_queue_drained", q_main.size(), 0);
    chk("ovf_queue_drained", q_ov.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
